// File: rtl/line_window_buffer.sv
// Multi-line window buffer: for each input pixel, emits the vertical column of
// KSIZE pixels (current row plus KSIZE-1 rows above) with a fixed 2-cycle latency.
module line_window_buffer #(
  parameter int KSIZE     = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 2000,
  parameter int Y_W       = 11,
  parameter int PAD_MODE  = 0,
  localparam int IDX_W    = $clog2(MAX_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         pix_i,
  input  logic                      dv_i,
  input  logic                      hs_i,
  input  logic                      vs_i,
  output logic                      dv_o,
  output logic                      hs_o,
  output logic                      vs_o,
  output logic [KSIZE*DATA_W-1:0]   col_o,
  output logic [IDX_W-1:0]          x_index_o,
  output logic [Y_W-1:0]            y_index_o,
  output logic                      full_o,
  output logic                      ovf_o
);

  localparam int NSLOT               = KSIZE - 1;
  localparam int SLOT_W              = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam bit SLOT_POW2           = (NSLOT & (NSLOT - 1)) == 0;
  localparam logic [IDX_W-1:0] X_MAX = IDX_W'(MAX_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_MAX = '1;

  // Stage 0: sync edge detect and line/row counters
  logic              hs_d_q, vs_d_q;
  logic [IDX_W-1:0]  x_q, x_cur, x_d;
  logic              sat_q, sat_cur, sat_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [SLOT_W-1:0] w_d;
  logic              ovf_q, ovf_d;
  logic              hs_rise, vs_rise, wr_en;
  logic [DATA_W-1:0] pix_mux;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hs_rise = hs_i & ~hs_d_q;
    vs_rise = vs_i & ~vs_d_q;
    pix_mux = dv_i ? pix_i : '0;
    x_cur   = x_q;
    sat_cur = sat_q;
    y_d     = y_q;
    if (vs_rise) begin
      x_cur   = '0;
      sat_cur = 1'b0;
      y_d     = '0;
    end else if (hs_rise) begin
      x_cur   = '0;
      sat_cur = 1'b0;
      y_d     = (y_q == Y_MAX) ? y_q : y_q + 1'b1;
    end
    // sat marks that slot X_MAX already holds this line's last storable pixel
    wr_en = dv_i & ~sat_cur & ~rst;
    x_d   = x_cur;
    sat_d = sat_cur;
    if (dv_i && !sat_cur) begin
      if (x_cur == X_MAX) sat_d = 1'b1;
      else                x_d   = x_cur + 1'b1;
    end
    ovf_d = (vs_rise ? 1'b0 : ovf_q) | (dv_i & sat_cur);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d_q <= 1'b0;
      vs_d_q <= 1'b0;
      x_q    <= '0;
      sat_q  <= 1'b0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      hs_d_q <= hs_i;
      vs_d_q <= vs_i;
      x_q    <= x_d;
      sat_q  <= sat_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
    end
  end

  generate
    if (SLOT_POW2) begin : g_slot_from_y
      assign w_d = y_d[SLOT_W-1:0];
    end else begin : g_slot_cnt
      localparam logic [SLOT_W-1:0] W_LAST = SLOT_W'(NSLOT - 1);
      logic [SLOT_W-1:0] w_q;
      always_comb begin
        w_d = w_q;
        if (vs_rise)                        w_d = '0;
        else if (hs_rise && y_q != Y_MAX)   w_d = (w_q == W_LAST) ? '0 : w_q + 1'b1;
      end
      always_ff @(posedge clk) begin
        if (rst) w_q <= '0;
        else     w_q <= w_d;
      end
    end
  endgenerate

  // Line storage: one read-first dual-port RAM per slot
  logic [DATA_W-1:0] rd_data [NSLOT];

  generate
    for (genvar s = 0; s < NSLOT; s++) begin : g_line
      logic [DATA_W-1:0] mem [MAX_WIDTH];
      logic [DATA_W-1:0] rd_q;
      // NOTE: RAM contents are deliberately not reset; only the read register is.
      always_ff @(posedge clk) begin
        if (wr_en && w_d == SLOT_W'(s)) mem[x_cur] <= pix_mux;
        if (rst) rd_q <= '0;
        else     rd_q <= mem[x_cur];
      end
      assign rd_data[s] = rd_q;
    end
  endgenerate

  // Stage 1: registered companion of the RAM read
  logic [DATA_W-1:0] pix1_q;
  logic [IDX_W-1:0]  x1_q;
  logic [Y_W-1:0]    y1_q;
  logic [SLOT_W-1:0] w1_q;
  logic              dv1_q, hs1_q, vs1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix1_q <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      w1_q   <= '0;
      dv1_q  <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
    end else begin
      pix1_q <= pix_mux;
      x1_q   <= x_cur;
      y1_q   <= y_d;
      w1_q   <= w_d;
      dv1_q  <= dv_i;
      hs1_q  <= hs_i;
      vs1_q  <= vs_i;
    end
  end

  // Slot holding the row d lines above the row that is writing slot w
  function automatic logic [SLOT_W-1:0] slot_of(input logic [SLOT_W-1:0] w, input int d);
    int t;
    t = int'(w) + NSLOT - d;
    if (t >= NSLOT) t = t - NSLOT;
    return SLOT_W'(t);
  endfunction

  logic [KSIZE*DATA_W-1:0] col_d;

  always_comb begin
    col_d = '0;
    for (int k = 0; k < KSIZE; k++) begin
      if (int'(y1_q) >= k)
        col_d[k*DATA_W +: DATA_W] = (k == 0) ? pix1_q : rd_data[slot_of(w1_q, k)];
      else if (PAD_MODE != 0)
        col_d[k*DATA_W +: DATA_W] = (y1_q == '0) ? pix1_q : rd_data[slot_of(w1_q, int'(y1_q))];
    end
  end

  // Stage 2: output registers
  logic [KSIZE*DATA_W-1:0] col_q;
  logic [IDX_W-1:0]        x2_q;
  logic [Y_W-1:0]          y2_q;
  logic                    dv2_q, hs2_q, vs2_q, full2_q, ovf2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      dv2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      full2_q <= 1'b0;
      ovf2_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      dv2_q   <= dv1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      full2_q <= dv1_q & (y1_q >= Y_W'(NSLOT));
      ovf2_q  <= ovf_q;
    end
  end

  assign col_o     = col_q;
  assign x_index_o = x2_q;
  assign y_index_o = y2_q;
  assign dv_o      = dv2_q;
  assign hs_o      = hs2_q;
  assign vs_o      = vs2_q;
  assign full_o    = full2_q;
  assign ovf_o     = ovf2_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: one instance per border mode, driven in lockstep.
module tb_line_window_buffer;

  localparam int KS = 5;
  localparam int DW = 8;
  localparam int MW = 16;
  localparam int YW = 11;
  localparam int IW = 4;
  localparam int CW = KS * DW;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [IW-1:0] x;
    logic [YW-1:0] y;
    logic dv, hs, vs, full, ovf;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix = '0;
  logic          dv = 1'b0, hs = 1'b0, vs = 1'b0;

  logic          dv_a, hs_a, vs_a, full_a, ovf_a;
  logic [CW-1:0] col_a;
  logic [IW-1:0] x_a;
  logic [YW-1:0] y_a;
  logic          dv_b, hs_b, vs_b, full_b, ovf_b;
  logic [CW-1:0] col_b;
  logic [IW-1:0] x_b;
  logic [YW-1:0] y_b;

  line_window_buffer #(.KSIZE(KS), .DATA_W(DW), .MAX_WIDTH(MW), .Y_W(YW), .PAD_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .pix_i(pix), .dv_i(dv), .hs_i(hs), .vs_i(vs),
    .dv_o(dv_a), .hs_o(hs_a), .vs_o(vs_a), .col_o(col_a),
    .x_index_o(x_a), .y_index_o(y_a), .full_o(full_a), .ovf_o(ovf_a));

  line_window_buffer #(.KSIZE(KS), .DATA_W(DW), .MAX_WIDTH(MW), .Y_W(YW), .PAD_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .pix_i(pix), .dv_i(dv), .hs_i(hs), .vs_i(vs),
    .dv_o(dv_b), .hs_o(hs_b), .vs_o(vs_b), .col_o(col_b),
    .x_index_o(x_b), .y_index_o(y_b), .full_o(full_b), .ovf_o(ovf_b));

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   rst_req = 1'b1;
  obs_t ha [4096];
  obs_t hb [4096];
  int   pc [32];
  int   gc, hc;

  // Samples outputs at the falling edge, then drives this cycle's inputs.
  // Inputs driven in step i show up in history entry i+2.
  task automatic step(input logic [DW-1:0] p, input logic d, input logic h, input logic v);
    @(negedge clk);
    if (cyc < 4096) begin
      ha[cyc] = {col_a, x_a, y_a, dv_a, hs_a, vs_a, full_a, ovf_a};
      hb[cyc] = {col_b, x_b, y_b, dv_b, hs_b, vs_b, full_b, ovf_b};
    end
    rst = rst_req;
    pix = p;
    dv  = d;
    hs  = h;
    vs  = v;
    cyc++;
  endtask

  // Sync pulse, one blank cycle, n pixels of value 16*row+x, optional dv gap before pixel gap_at
  task automatic send_line(input int row, input int n, input bit vsf, input int gap_at, input int hs_len);
    hc = cyc;
    for (int i = 0; i < hs_len; i++) step('0, 1'b0, 1'b1, vsf);
    step('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        gc = cyc;
        step('0, 1'b0, 1'b0, 1'b0);
      end
      pc[i] = cyc;
      step(DW'(16 * row + i), 1'b1, 1'b0, 1'b0);
    end
    repeat (3) step('0, 1'b0, 1'b0, 1'b0);
  endtask

  // Row-based reference: slice k is row y-k, or the border value above the frame
  function automatic obs_t exp_px(input int y, input int x, input bit pad, input bit ovf);
    obs_t e;
    e = '0;
    for (int k = 0; k < KS; k++) begin
      if (k <= y)   e.col[k*DW +: DW] = DW'(16 * (y - k) + x);
      else if (pad) e.col[k*DW +: DW] = DW'(x);
    end
    e.x    = IW'(x);
    e.y    = YW'(y);
    e.dv   = 1'b1;
    e.full = (y >= KS - 1);
    e.ovf  = ovf;
    return e;
  endfunction

  task automatic test_reset();
    int r;
    rst_req = 1'b1;
    repeat (3) step('0, 1'b0, 1'b0, 1'b0);
    rst_req = 1'b0;
    repeat (4) step('0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (ha[cyc-1] !== obs_t'(0)) begin
      nerr++;
      $display("FAIL reset_idle_a: got %h expected 0", ha[cyc-1]);
    end
    nvec++;
    if (hb[cyc-1] !== obs_t'(0)) begin
      nerr++;
      $display("FAIL reset_idle_b: got %h expected 0", hb[cyc-1]);
    end
    // Row 1 in progress, then a 3-cycle reset while pixels keep arriving
    step('0, 1'b0, 1'b1, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(DW'(j), 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(DW'(16 + j), 1'b1, 1'b0, 1'b0);
    r = cyc;
    rst_req = 1'b1;
    repeat (3) step(8'hAA, 1'b1, 1'b0, 1'b0);
    rst_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      pc[j] = cyc;
      step(DW'(j), 1'b1, 1'b0, 1'b0);
    end
    repeat (3) step('0, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      nvec++;
      if (ha[r+j] !== obs_t'(0) || hb[r+j] !== obs_t'(0)) begin
        nerr++;
        $display("FAIL reset_hold cycle %0d: got %h / %h expected 0", j, ha[r+j], hb[r+j]);
      end
    end
    for (int j = 0; j < 3; j++) begin
      nvec++;
      if ({ha[pc[j]+2].x, ha[pc[j]+2].y, ha[pc[j]+2].dv} !== {IW'(j), YW'(0), 1'b1}) begin
        nerr++;
        $display("FAIL reset_resume px %0d: got x=%0d y=%0d dv=%b expected x=%0d y=0 dv=1",
                 j, ha[pc[j]+2].x, ha[pc[j]+2].y, ha[pc[j]+2].dv, j);
      end
    end
  endtask

  task automatic test_frame();
    for (int row = 0; row < 8; row++) begin
      send_line(row, 8, row == 0, (row == 7) ? 3 : -1, 1);
      for (int x = 0; x < 8; x++) begin
        nvec++;
        if (ha[pc[x]+2] !== exp_px(row, x, 1'b0, 1'b0)) begin
          nerr++;
          $display("FAIL frame_pad0 row %0d x %0d: got %h expected %h",
                   row, x, ha[pc[x]+2], exp_px(row, x, 1'b0, 1'b0));
        end
        nvec++;
        if (hb[pc[x]+2] !== exp_px(row, x, 1'b1, 1'b0)) begin
          nerr++;
          $display("FAIL frame_pad1 row %0d x %0d: got %h expected %h",
                   row, x, hb[pc[x]+2], exp_px(row, x, 1'b1, 1'b0));
        end
      end
      if (row == 0) begin
        nvec++;
        if ({ha[hc+1].hs, ha[hc+1].vs, ha[hc+2].hs, ha[hc+2].vs} !== 4'b0011) begin
          nerr++;
          $display("FAIL sync_latency: got %b expected 0011",
                   {ha[hc+1].hs, ha[hc+1].vs, ha[hc+2].hs, ha[hc+2].vs});
        end
        nvec++;
        if ({ha[pc[0]+1].dv, ha[pc[0]+2].dv} !== 2'b01) begin
          nerr++;
          $display("FAIL dv_latency: got %b expected 01", {ha[pc[0]+1].dv, ha[pc[0]+2].dv});
        end
      end
      if (row == 7) begin
        nvec++;
        if ({ha[gc+2].dv, ha[gc+2].x} !== {1'b0, IW'(3)}) begin
          nerr++;
          $display("FAIL gap_hold: got dv=%b x=%0d expected dv=0 x=3", ha[gc+2].dv, ha[gc+2].x);
        end
      end
    end
  endtask

  task automatic test_overflow();
    send_line(8, 20, 1'b0, -1, 1);
    for (int i = 0; i < 20; i++) begin
      nvec++;
      if ({ha[pc[i]+2].x, ha[pc[i]+2].dv, ha[pc[i]+2].ovf} !==
          {IW'((i < MW) ? i : MW - 1), 1'b1, (i >= MW)}) begin
        nerr++;
        $display("FAIL overflow px %0d: got x=%0d dv=%b ovf=%b expected x=%0d dv=1 ovf=%b",
                 i, ha[pc[i]+2].x, ha[pc[i]+2].dv, ha[pc[i]+2].ovf,
                 (i < MW) ? i : MW - 1, (i >= MW));
      end
    end
    send_line(9, 8, 1'b0, -1, 1);
    for (int x = 0; x < 8; x++) begin
      nvec++;
      if (ha[pc[x]+2] !== exp_px(9, x, 1'b0, 1'b1)) begin
        nerr++;
        $display("FAIL ovf_sticky_a x %0d: got %h expected %h", x, ha[pc[x]+2], exp_px(9, x, 1'b0, 1'b1));
      end
      nvec++;
      if (hb[pc[x]+2] !== exp_px(9, x, 1'b1, 1'b1)) begin
        nerr++;
        $display("FAIL ovf_sticky_b x %0d: got %h expected %h", x, hb[pc[x]+2], exp_px(9, x, 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_sync();
    // New frame with hs and vs rising together, then a 3-cycle-wide hs pulse
    for (int row = 0; row < 2; row++) begin
      send_line(row, 8, row == 0, -1, (row == 0) ? 1 : 3);
      for (int x = 0; x < 8; x++) begin
        nvec++;
        if (ha[pc[x]+2] !== exp_px(row, x, 1'b0, 1'b0)) begin
          nerr++;
          $display("FAIL new_frame_a row %0d x %0d: got %h expected %h",
                   row, x, ha[pc[x]+2], exp_px(row, x, 1'b0, 1'b0));
        end
        nvec++;
        if (hb[pc[x]+2] !== exp_px(row, x, 1'b1, 1'b0)) begin
          nerr++;
          $display("FAIL new_frame_b row %0d x %0d: got %h expected %h",
                   row, x, hb[pc[x]+2], exp_px(row, x, 1'b1, 1'b0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overflow();
    test_sync();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
